// File: rtl/xintf_slave_mem.sv
// XINTF bus slave fronting an on-chip word memory; async strobes are 2-FF synchronized.
// Optional doorbell interrupt on writes to DB_ADDR when XINTF_DOORBELL_EN is defined.
module xintf_slave_mem #(
  parameter int                 ADDR_W    = 15,
  parameter int                 DATA_W    = 16,
  parameter int                 MEM_AW    = 11,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 15'h0,
  parameter logic [ADDR_W-1:0]  DB_ADDR   = 15'h7FF
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] address,
  input  logic              nCS,
  input  logic              nRD,
  input  logic              nWR,
  inout  wire  [DATA_W-1:0] data,
  output logic              data_oe,
  output logic              wr_stb,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              proto_err,
  output logic              dsp_interrupt
);

  typedef enum logic [2:0] {IDLE, WR_ACT, RD_FETCH, RD_DRIVE, ERR_WAIT} state_t;

  state_t            state;
  logic [2:0]        sync1, sync2;
  logic              nCS_s, nRD_s, nWR_s;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q, rd_q;
  logic              hit_q, wr_hit, armed;
  logic [DATA_W-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (!nRST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {nCS, nRD, nWR};
      sync2 <= sync1;
    end
  end
  assign {nCS_s, nRD_s, nWR_s} = sync2;

  assign hit_q = (addr_q[ADDR_W-1:MEM_AW] == BASE_ADDR[ADDR_W-1:MEM_AW]);

  // Memory is written the cycle after the commit strobe; a read cannot reach
  // RD_FETCH before that write has landed.
  always_ff @(posedge clk) begin
    if (wr_stb && wr_hit) mem[wr_addr] <= wr_data;
    if (state == RD_FETCH) rd_q <= mem[addr_q[MEM_AW-1:0]];
  end

  assign data = data_oe ? (hit_q ? rd_q : '0) : 'z;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state     <= IDLE;
      data_oe   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_hit    <= 1'b0;
      proto_err <= 1'b0;
      addr_q    <= '0;
      word_q    <= '0;
      armed     <= 1'b1;
`ifdef XINTF_DOORBELL_EN
      dsp_interrupt <= 1'b0;
`endif
    end else begin
      wr_stb <= 1'b0;
`ifdef XINTF_DOORBELL_EN
      dsp_interrupt <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // armed blocks re-acceptance of a strobe still low from the last access
          if (!nRD_s && !nWR_s) begin
            state     <= ERR_WAIT;
            proto_err <= 1'b1;
            armed     <= 1'b0;
          end else if (armed && !nCS_s && !nWR_s) begin
            state  <= WR_ACT;
            addr_q <= address;
            word_q <= data;
            armed  <= 1'b0;
          end else if (armed && !nCS_s && !nRD_s) begin
            state  <= RD_FETCH;
            addr_q <= address;
            armed  <= 1'b0;
          end else if (nRD_s && nWR_s) begin
            armed <= 1'b1;
          end
        end
        WR_ACT: begin
          if (nWR_s) begin
            wr_stb  <= 1'b1;
            wr_addr <= addr_q[MEM_AW-1:0];
            wr_data <= word_q;
            wr_hit  <= hit_q;
`ifdef XINTF_DOORBELL_EN
            dsp_interrupt <= hit_q && (addr_q == DB_ADDR);
`endif
            state   <= IDLE;
          end else if (nCS_s) begin
            proto_err <= 1'b1;
            state     <= IDLE;
          end else begin
            word_q <= data;
          end
        end
        RD_FETCH: begin
          data_oe <= 1'b1;
          state   <= RD_DRIVE;
        end
        RD_DRIVE: begin
          if (nRD_s || nCS_s) begin
            data_oe <= 1'b0;
            state   <= IDLE;
          end
        end
        ERR_WAIT: if (nRD_s && nWR_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef XINTF_DOORBELL_EN
  assign dsp_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_xintf_slave_mem.sv
// Directed bench for xintf_slave_mem; a negedge monitor scores writes and reads from queues.
module tb_xintf_slave_mem;
  logic        clk = 0;
  logic        nRST = 0;
  logic [14:0] address = '0;
  logic        nCS = 1, nRD = 1, nWR = 1;
  wire  [15:0] data;
  logic [15:0] tb_data = '0;
  logic        tb_drv = 0;
  logic        data_oe, wr_stb, proto_err, dsp_interrupt;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;

  int errors = 0, checks = 0;
  int stb_cnt = 0, irq_cnt = 0;
  logic [26:0] wrq[$];
  logic [15:0] rdq[$];
  logic prev_stb = 0, prev_oe = 0;

  assign data = tb_drv ? tb_data : 'z;
  always #5 clk = ~clk;

  xintf_slave_mem dut (
    .clk(clk), .nRST(nRST), .address(address), .nCS(nCS), .nRD(nRD), .nWR(nWR),
    .data(data), .data_oe(data_oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .proto_err(proto_err), .dsp_interrupt(dsp_interrupt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write strobe or starts driving.
  always @(negedge clk) begin
    logic [26:0] ew;
    if (wr_stb === 1'b1) begin
      stb_cnt++;
      if (prev_stb) chk("wr_stb_width", 1, 0);
      if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        ew = wrq.pop_front();
        chk("wr_beat", {5'b0, wr_addr, wr_data}, {5'b0, ew});
      end
    end
    if (dsp_interrupt === 1'b1) irq_cnt++;
    if (data_oe === 1'b1 && !prev_oe) begin
      if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", {16'h0, data}, {16'h0, rdq.pop_front()});
    end
    prev_stb = (wr_stb === 1'b1);
    prev_oe  = (data_oe === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    nRST = 0; tick(3); nRST = 1; tick(1);
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d, input int low);
    wrq.push_back({a[10:0], d});
    address = a; tb_data = d; tb_drv = 1; nCS = 0; nWR = 0;
    tick(low);
    nWR = 1; nCS = 1;
    tick(3);
    tb_drv = 0;
    tick(2);
  endtask

  task automatic rd(input logic [14:0] a, input logic [15:0] exp);
    rdq.push_back(exp);
    address = a; nCS = 0; nRD = 0;
    tick(3); chk("rd_oe_early", data_oe, 0);
    tick(1); chk("rd_oe_on", data_oe, 1);
    tick(2); nRD = 1; nCS = 1;
    tick(2); chk("rd_oe_hold", data_oe, 1);
    tick(1); chk("rd_oe_off", data_oe, 0);
    tick(1);
  endtask

  initial begin
    int s, ic;
    tick(3);
    chk("rst_oe", data_oe, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_irq", dsp_interrupt, 0);
    nRST = 1; tick(1);

    wr(15'h0005, 16'h1234, 6);
    rd(15'h0005, 16'h1234);

    wr(15'h0000, 16'h1111, 2);
    wr(15'h4000, 16'hBEEF, 2);
    rd(15'h0000, 16'h1111);
    rd(15'h4000, 16'h0000);

    ic = irq_cnt;
    wr(15'h07FF, 16'h0001, 3);
`ifdef XINTF_DOORBELL_EN
    chk("doorbell", irq_cnt - ic, 1);
`else
    chk("doorbell_off", irq_cnt - ic, 0);
`endif

    // Read and write strobes together
    s = stb_cnt;
    address = 15'h0005; nCS = 0; nRD = 0; nWR = 0;
    tick(4);
    chk("err_flag", proto_err, 1);
    chk("err_oe", data_oe, 0);
    nRD = 1; nWR = 1; nCS = 1;
    tick(4);
    chk("err_no_stb", stb_cnt - s, 0);
    rd(15'h0005, 16'h1234);
    chk("err_sticky", proto_err, 1);

    // Chip select dropped before the write strobe
    do_reset();
    chk("rst_err_clr", proto_err, 0);
    s = stb_cnt;
    address = 15'h0006; tb_data = 16'h5555; tb_drv = 1; nCS = 0; nWR = 0;
    tick(4); nCS = 1;
    tick(2); nWR = 1;
    tick(4); tb_drv = 0;
    chk("abort_err", proto_err, 1);
    chk("abort_no_stb", stb_cnt - s, 0);

    // Reset while driving read data
    do_reset();
    rdq.push_back(16'h1234);
    address = 15'h0005; nCS = 0; nRD = 0;
    tick(5); chk("rdrst_oe_on", data_oe, 1);
    nRST = 0;
    tick(1);
    chk("rdrst_oe_off", data_oe, 0);
    chk("rdrst_err", proto_err, 0);
    nRD = 1; nCS = 1;
    tick(2); nRST = 1; tick(2);

    for (int i = 0; i < 2048; i++) wr(i[14:0], i[15:0] ^ 16'hA5A5, 2);
    for (int i = 0; i < 2048; i++) rd(i[14:0], i[15:0] ^ 16'hA5A5);
    chk("sweep_err", proto_err, 0);

    tick(4);
    chk("wrq_empty", wrq.size(), 0);
    chk("rdq_empty", rdq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
